// File: rtl/uart_cmd_framer_pkg.sv
// Shared types and defaults for the UART command framer: FSM states, error bundle, byte constants.
package uart_cmd_framer_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 10416;
  localparam logic [7:0]  SOF_BYTE_DEF     = 8'h3F;
  localparam int unsigned LEN_W            = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_CMD  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } state_e;

  typedef struct packed {
    logic err_chk;
    logic err_len;
    logic err_timeout;
    logic err_overrun;
  } err_t;

  // States in which the inter-byte timeout is armed.
  function automatic logic timer_active(input state_e s);
    return (s == ST_LEN) || (s == ST_CMD) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_cmd_framer_timer.sv
// Inter-byte timeout counter; expired is a registered 1-cycle pulse seen in the cycle the count would hit the limit.
module uart_cmd_framer_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;

  // Pulse is registered one edge early so the framer can act on it in the limit cycle.
  always_comb begin
    count_d   = count_q;
    expired_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q < CNT_W'(TIMEOUT_CYCLES))) begin
      count_d   = count_q + CNT_W'(1);
      expired_d = (count_d == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/uart_cmd_framer.sv
// Frames the uart_rx_ctrl byte stream (SOF, LEN, CMD, payload, XOR CHK) into held commands for the dispatcher.
module uart_cmd_framer
  import uart_cmd_framer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned TIMEOUT_BITS = 20,
  parameter int unsigned MAX_PAYLOAD  = 4,
  parameter logic [7:0]  SOF_BYTE     = SOF_BYTE_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     done_rx,
  input  logic [7:0]               byte_rx,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_op,
  output logic [LEN_W-1:0]         cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] cmd_data,
  output logic                     busy,
  output logic                     err_chk,
  output logic                     err_len,
  output logic                     err_timeout,
  output logic                     err_overrun
);

  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned IDX_W          = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned DATA_W         = 8 * MAX_PAYLOAD;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         op_q, op_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [7:0]         chk_q, chk_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  err_t               err_q, err_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               busy_q, busy_d;

  logic               timer_enable_c;
  logic               timer_clear_c;
  logic               timer_expired;

  // Timer is held cleared outside the frame, so entering LEN always starts from zero.
  assign timer_enable_c = timer_active(state_q);
  assign timer_clear_c  = done_rx || !timer_active(state_q);

  uart_cmd_framer_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (timer_enable_c),
    .clear   (timer_clear_c),
    .expired (timer_expired)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    op_d    = op_q;
    data_d  = data_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    err_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (done_rx && (byte_rx == SOF_BYTE)) begin
          state_d = ST_LEN;
          data_d  = '0;
          chk_d   = '0;
          idx_d   = '0;
        end
      end
      ST_LEN: begin
        if (done_rx) begin
          if (byte_rx > 8'(MAX_PAYLOAD)) begin
            err_d.err_len = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            len_d   = LEN_W'(byte_rx);
            chk_d   = byte_rx;
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (done_rx) begin
          op_d    = byte_rx;
          chk_d   = chk_q ^ byte_rx;
          idx_d   = '0;
          state_d = (len_q == '0) ? ST_CHK : ST_DATA;
        end
      end
      ST_DATA: begin
        if (done_rx) begin
          data_d[{idx_q, 3'b000} +: 8] = byte_rx;
          chk_d = chk_q ^ byte_rx;
          idx_d = idx_q + IDX_W'(1);
          if (LEN_W'(idx_q) == (len_q - LEN_W'(1))) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (done_rx) begin
          if (byte_rx == chk_q) begin
            state_d = ST_HOLD;
          end else begin
            err_d.err_chk = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (done_rx) begin
          err_d.err_overrun = 1'b1;
        end
        if (cmd_valid_q && cmd_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A byte arriving in the expiry cycle takes priority over the timeout.
    if (timer_active(state_q) && !done_rx && timer_expired) begin
      err_d.err_timeout = 1'b1;
      state_d           = ST_IDLE;
    end

    cmd_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      op_q        <= op_d;
      data_q      <= data_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = op_q;
  assign cmd_len     = len_q;
  assign cmd_data    = data_q;
  assign busy        = busy_q;
  assign err_chk     = err_q.err_chk;
  assign err_len     = err_q.err_len;
  assign err_timeout = err_q.err_timeout;
  assign err_overrun = err_q.err_overrun;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer: directed frame table, multi-cycle corner sequences, random frames.
module tb_uart_cmd_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        done_rx;
  logic [7:0]  byte_rx;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        busy;
  logic        err_chk;
  logic        err_len;
  logic        err_timeout;
  logic        err_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_cmd_framer #(
    .CLKS_PER_BIT(16),
    .TIMEOUT_BITS(4),
    .MAX_PAYLOAD (4),
    .SOF_BYTE    (8'h3F)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .done_rx     (done_rx),
    .byte_rx     (byte_rx),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .cmd_data    (cmd_data),
    .busy        (busy),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  // Frame bytes are packed first-byte-lowest into frame.
  typedef struct {
    string       name;
    logic [63:0] frame;
    int          n;
    logic        exp_valid;
    logic        exp_chk;
    logic        exp_len;
    logic [7:0]  op;
    logic [2:0]  len;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input string nm, input logic [63:0] fr, input int n,
                              input logic v, input logic c, input logic l,
                              input logic [7:0] op, input logic [2:0] len, input logic [31:0] data);
    vec_t r;
    r.name = nm; r.frame = fr; r.n = n;
    r.exp_valid = v; r.exp_chk = c; r.exp_len = l;
    r.op = op; r.len = len; r.data = data;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    done_rx = 1'b1;
    byte_rx = b;
    tick();
    done_rx = 1'b0;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic gap(input int maxc);
    repeat ($urandom_range(0, maxc)) tick();
  endtask

  task automatic check_frame(input string nm, input logic [7:0] op, input logic [2:0] len,
                             input logic [31:0] data);
    check({nm, "_valid"}, 64'(cmd_valid), 64'(1));
    check({nm, "_op"},    64'(cmd_op),    64'(op));
    check({nm, "_len"},   64'(cmd_len),   64'(len));
    check({nm, "_data"},  64'(cmd_data),  64'(data));
    check({nm, "_busy"},  64'(busy),      64'(1));
  endtask

  // Hold the frame with cmd_ready low, then accept it and expect cmd_valid to drop.
  task automatic hold_and_accept(input string nm, input int hold, input logic [7:0] op,
                                 input logic [2:0] len, input logic [31:0] data);
    cmd_ready = 1'b0;
    repeat (hold) tick();
    check_frame({nm, "_held"}, op, len, data);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check({nm, "_drop_valid"}, 64'(cmd_valid), 64'(0));
    check({nm, "_drop_busy"},  64'(busy),      64'(0));
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_valid"}, 64'(cmd_valid), 64'(0));
    check({nm, "_op"},    64'(cmd_op),    64'(0));
    check({nm, "_len"},   64'(cmd_len),   64'(0));
    check({nm, "_data"},  64'(cmd_data),  64'(0));
    check({nm, "_busy"},  64'(busy),      64'(0));
    check({nm, "_errs"},  64'({err_chk, err_len, err_timeout, err_overrun}), 64'(0));
  endtask

  logic [7:0]  r_op, r_chk, r_b;
  logic [31:0] r_data;
  int          r_kind, r_len;

  initial begin
    reset = 1'b1; done_rx = 1'b0; byte_rx = 8'h00; cmd_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    vecs[0] = mk("good",     64'hED55AA10023F,     6, 1, 0, 0, 8'h10, 3'd2, 32'h000055AA);
    vecs[1] = mk("badchk",   64'h0020003F,         4, 0, 1, 0, 8'h00, 3'd0, 32'h0);
    vecs[2] = mk("resend",   64'h2020003F,         4, 1, 0, 0, 8'h20, 3'd0, 32'h0);
    vecs[3] = mk("oversize", 64'h053F,             2, 0, 0, 1, 8'h00, 3'd0, 32'h0);
    vecs[4] = mk("idlejunk", 64'h2010,             2, 0, 0, 0, 8'h00, 3'd0, 32'h0);
    vecs[5] = mk("sofdata",  64'h7C3F42013F,       5, 1, 0, 0, 8'h42, 3'd1, 32'h0000003F);
    vecs[6] = mk("maxlen",   64'h414433221101043F, 8, 1, 0, 0, 8'h01, 3'd4, 32'h44332211);
    vecs[7] = mk("shorter",  64'h073F3F05023F,     6, 1, 0, 0, 8'h05, 3'd2, 32'h00003F3F);

    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].frame[8*j +: 8]);
      check({vecs[i].name, "_valid"},   64'(cmd_valid), 64'(vecs[i].exp_valid));
      check({vecs[i].name, "_err_chk"}, 64'(err_chk),   64'(vecs[i].exp_chk));
      check({vecs[i].name, "_err_len"}, 64'(err_len),   64'(vecs[i].exp_len));
      check({vecs[i].name, "_busy"},    64'(busy),      64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        hold_and_accept(vecs[i].name, 5, vecs[i].op, vecs[i].len, vecs[i].data);
      end else begin
        tick();
        check({vecs[i].name, "_pulse_end"}, 64'({err_chk, err_len}), 64'(0));
      end
    end

    // Timeout: error lands exactly 64 edges after the last accepted byte.
    send_byte(8'h3F); send_byte(8'h01);
    repeat (63) tick();
    check("tmo_before", 64'(err_timeout), 64'(0));
    check("tmo_busy_before", 64'(busy), 64'(1));
    tick();
    check("tmo_pulse", 64'(err_timeout), 64'(1));
    check("tmo_busy_after", 64'(busy), 64'(0));
    tick();
    check("tmo_pulse_end", 64'(err_timeout), 64'(0));

    // Byte coincident with expiry is processed and the frame continues.
    send_byte(8'h3F); send_byte(8'h01);
    repeat (63) tick();
    send_byte(8'h42);
    check("coinc_no_tmo", 64'(err_timeout), 64'(0));
    check("coinc_busy", 64'(busy), 64'(1));
    send_byte(8'h07); send_byte(8'h44);
    hold_and_accept("coinc", 0, 8'h42, 3'd1, 32'h00000007);

    // Overrun while holding a frame leaves it untouched.
    send_byte(8'h3F); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'hED);
    send_byte(8'h77);
    check("overrun_pulse", 64'(err_overrun), 64'(1));
    check_frame("overrun_frame", 8'h10, 3'd2, 32'h000055AA);
    tick();
    check("overrun_pulse_end", 64'(err_overrun), 64'(0));
    hold_and_accept("overrun", 2, 8'h10, 3'd2, 32'h000055AA);

    // Reset mid-frame discards it silently.
    send_byte(8'h3F); send_byte(8'h02); send_byte(8'h10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midreset");
    tick();
    check("midreset_errs", 64'({err_chk, err_len, err_timeout, err_overrun}), 64'(0));
    send_byte(8'h3F); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'hED);
    hold_and_accept("after_reset", 1, 8'h10, 3'd2, 32'h000055AA);

    // Random frames checked against a frame-level model.
    for (int f = 0; f < 40; f++) begin
      r_kind = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) begin
        r_b = 8'($urandom);
        if (r_b == 8'h3F) r_b = 8'h00;
        send_byte(r_b);
        check("rnd_junk_busy", 64'(busy), 64'(0));
      end
      send_byte(8'h3F);
      check("rnd_sof_busy", 64'(busy), 64'(1));
      gap(6);
      if (r_kind == 3) begin
        send_byte(8'($urandom_range(5, 255)));
        check("rnd_err_len", 64'(err_len), 64'(1));
        check("rnd_len_busy", 64'(busy), 64'(0));
        tick();
        check("rnd_err_len_end", 64'(err_len), 64'(0));
      end else begin
        r_len  = $urandom_range(0, 4);
        r_op   = 8'($urandom);
        r_chk  = 8'(r_len) ^ r_op;
        r_data = '0;
        send_byte(8'(r_len)); gap(6);
        send_byte(r_op); gap(6);
        for (int k = 0; k < r_len; k++) begin
          r_b = 8'($urandom);
          r_data[8*k +: 8] = r_b;
          r_chk = r_chk ^ r_b;
          send_byte(r_b); gap(6);
        end
        if (r_kind == 2) begin
          send_byte(r_chk ^ 8'($urandom_range(1, 255)));
          check("rnd_err_chk", 64'(err_chk), 64'(1));
          check("rnd_chk_novalid", 64'({cmd_valid, busy}), 64'(0));
        end else begin
          send_byte(r_chk);
          check("rnd_no_err", 64'({err_chk, err_len, err_timeout}), 64'(0));
          check_frame("rnd", r_op, 3'(r_len), r_data);
          hold_and_accept("rnd", $urandom_range(0, 3), r_op, 3'(r_len), r_data);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
